// File: rtl/gf180mcu_fd_sc_mcu7t5v0__latrsnq_drv.sv
// gf180mcu_fd_sc_mcu7t5v0__latrsnq_drv
// Sequencer that sits in front of a WIDTH-bit latrsnq latch bank. It turns
// single-cycle write, clear and preset requests into timed E / D / RN / SETN
// waveforms with a setup phase, a pulse phase and a hold phase.
// Optional feature macro: LATRSNQ_DRV_READBACK_EN. When it is defined, a
// one-cycle CHECK phase compares the bank output Q_I against the value the
// operation should have produced, and sets the sticky ERR flag on a mismatch.
module gf180mcu_fd_sc_mcu7t5v0__latrsnq_drv #(
    parameter int WIDTH     = 8,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ_VALID,
    output logic             REQ_READY,
    input  logic [1:0]       REQ_OP,
    input  logic [WIDTH-1:0] REQ_DATA,
    output logic             E,
    output logic [WIDTH-1:0] D,
    output logic             RN,
    output logic             SETN,
    output logic             DONE,
    input  logic [WIDTH-1:0] Q_I,
    output logic             ERR
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_CHECK = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam logic [1:0] OP_WRITE  = 2'b00;
    localparam logic [1:0] OP_CLEAR  = 2'b01;
    localparam logic [1:0] OP_PRESET = 2'b10;
    localparam logic [1:0] OP_NOP    = 2'b11;

    // Terminal values of the 4-bit phase counter.
    localparam logic [3:0] SETUP_LAST = 4'(SETUP_CYC - 1);
    localparam logic [3:0] PULSE_LAST = 4'(PULSE_CYC - 1);
    localparam logic [3:0] HOLD_LAST  = 4'(HOLD_CYC - 1);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             e_q, e_d;
    logic             rn_q, rn_d;
    logic             setn_q, setn_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;
    logic             accept_s;

    assign accept_s = REQ_VALID & ready_q;

`ifdef LATRSNQ_DRV_READBACK_EN
    logic err_q, err_d;

    // Value the bank must show after the given operation has completed.
    function automatic logic [WIDTH-1:0] expected_q(input logic [1:0] op,
                                                    input logic [WIDTH-1:0] data);
        logic [WIDTH-1:0] val;
        case (op)
            OP_WRITE:  val = data;
            OP_CLEAR:  val = {WIDTH{1'b0}};
            OP_PRESET: val = {WIDTH{1'b1}};
            default:   val = data;
        endcase
        return val;
    endfunction

    // Sticky readback mismatch detection, sampled only in the CHECK phase.
    always_comb begin
        err_d = err_q;
        if (state_q == ST_CHECK) begin
            err_d = err_q | (Q_I != expected_q(op_q, d_q));
        end else begin
            err_d = err_q;
        end
    end

    assign ERR = err_q;
`else
    logic unused_q_s;
    assign unused_q_s = ^Q_I;
    assign ERR        = 1'b0;
`endif

    // Next-state logic for the phase sequencer plus next values of the registered controls.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        d_d     = d_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept_s) begin
                    op_d  = REQ_OP;
                    cnt_d = 4'd0;
                    if (REQ_OP == OP_WRITE) begin
                        d_d = REQ_DATA;
                    end else begin
                        d_d = d_q;
                    end
                    if (REQ_OP == OP_NOP) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SETUP;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = ST_PULSE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_PULSE: begin
                if (cnt_q == PULSE_LAST) begin
                    state_d = ST_HOLD;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
`ifdef LATRSNQ_DRV_READBACK_EN
                    state_d = ST_CHECK;
`else
                    state_d = ST_DONE;
`endif
                    cnt_d = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_CHECK: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        // Controls are decoded from the next state so they leave a flop directly.
        e_d     = (state_d == ST_PULSE) && (op_d == OP_WRITE);
        rn_d    = !((state_d == ST_PULSE) && (op_d == OP_CLEAR));
        setn_d  = !((state_d == ST_PULSE) && (op_d == OP_PRESET));
        done_d  = (state_d == ST_DONE);
        ready_d = (state_d == ST_IDLE) || (state_d == ST_DONE);
    end

    // State, data and control registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            op_q    <= OP_NOP;
            // D is only cleared once E is already low, so the latch keeps its hold margin.
            d_q     <= e_q ? d_q : {WIDTH{1'b0}};
            e_q     <= 1'b0;
            rn_q    <= 1'b1;
            setn_q  <= 1'b1;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
`ifdef LATRSNQ_DRV_READBACK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            d_q     <= d_d;
            e_q     <= e_d;
            rn_q    <= rn_d;
            setn_q  <= setn_d;
            done_q  <= done_d;
            ready_q <= ready_d;
`ifdef LATRSNQ_DRV_READBACK_EN
            err_q   <= err_d;
`endif
        end
    end

    assign REQ_READY = ready_q;
    assign E         = e_q;
    assign D         = d_q;
    assign RN        = rn_q;
    assign SETN      = setn_q;
    assign DONE      = done_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__latrsnq_drv.sv
// Testbench for gf180mcu_fd_sc_mcu7t5v0__latrsnq_drv.
// The driver pushes one expected-response record per request into a
// scoreboard queue. A negedge monitor tracks control activity from each
// accept and checks the head record whenever DONE pulses.
module tb_gf180mcu_fd_sc_mcu7t5v0__latrsnq_drv;

`ifdef LATRSNQ_DRV_READBACK_EN
    localparam int RB = 1;
`else
    localparam int RB = 0;
`endif
    localparam int LAT   = 5 + RB;
    localparam int FIRST = 2;

    localparam logic [1:0] OPW = 2'b00;
    localparam logic [1:0] OPC = 2'b01;
    localparam logic [1:0] OPP = 2'b10;
    localparam logic [1:0] OPN = 2'b11;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       REQ_VALID = 1'b0;
    logic       REQ_READY;
    logic [1:0] REQ_OP = 2'b11;
    logic [7:0] REQ_DATA = 8'h00;
    logic       E;
    logic [7:0] D;
    logic       RN;
    logic       SETN;
    logic       DONE;
    logic [7:0] Q_I;
    logic       ERR;

    logic [7:0] latch_m = 8'h00;
    logic       force_en = 1'b0;
    logic [7:0] force_val = 8'h00;
    assign Q_I = force_en ? force_val : latch_m;

    gf180mcu_fd_sc_mcu7t5v0__latrsnq_drv dut (
        .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_OP(REQ_OP), .REQ_DATA(REQ_DATA), .E(E), .D(D), .RN(RN),
        .SETN(SETN), .DONE(DONE), .Q_I(Q_I), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] d;
        int         lat;
        int         first;
        int         e_n;
        int         rn_n;
        int         setn_n;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    logic [7:0] cur_d = 8'h00;
    logic       exp_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural latch bank: RN dominates SETN, E loads D.
    always @(negedge CLK) begin
        if (!RN) latch_m = 8'h00;
        else if (!SETN) latch_m = 8'hFF;
        else if (E) latch_m = D;
    end

    // Monitor: measure each operation from its accept and check it at DONE.
    int cyc = 0, acc_cyc = 0, e_n = 0, rn_n = 0, setn_n = 0, first = 0;
    int overlap = 0, d_bad = 0, rdy_bad = 0;
    bit busy = 1'b0;
    always @(negedge CLK) begin
        exp_t x;
        int act;
        cyc++;
        if (RST) begin
            busy = 1'b0;
        end else begin
            if (busy) begin
                act = int'(E) + int'(!RN) + int'(!SETN);
                if (act > 1) overlap++;
                if (E) e_n++;
                if (!RN) rn_n++;
                if (!SETN) setn_n++;
                if (act > 0 && first == 0) first = cyc - acc_cyc;
                if (!DONE && REQ_READY) rdy_bad++;
                if (sb.size() > 0 && D !== sb[0].d) d_bad++;
            end
            if (DONE) begin
                chk("done_with_pending", 32'(sb.size() > 0 && busy), 32'd1);
                if (sb.size() > 0) begin
                    x = sb.pop_front();
                    chk("latency", 32'(cyc - acc_cyc), 32'(x.lat));
                    chk("first_ctl", 32'(first), 32'(x.first));
                    chk("e_cycles", 32'(e_n), 32'(x.e_n));
                    chk("rn_cycles", 32'(rn_n), 32'(x.rn_n));
                    chk("setn_cycles", 32'(setn_n), 32'(x.setn_n));
                    chk("d_at_done", 32'(D), 32'(x.d));
                    chk("d_stable", 32'(d_bad), 32'd0);
                    chk("ctl_overlap", 32'(overlap), 32'd0);
                    chk("ready_while_busy", 32'(rdy_bad), 32'd0);
                    chk("ready_at_done", 32'(REQ_READY), 32'd1);
                    chk("err_at_done", 32'(ERR), 32'(x.err));
                end
                busy = 1'b0;
            end
            if (REQ_VALID && REQ_READY) begin
                busy = 1'b1; acc_cyc = cyc; first = 0;
                e_n = 0; rn_n = 0; setn_n = 0; overlap = 0; d_bad = 0; rdy_bad = 0;
            end
        end
    end

    // Present a request from just after a rising edge; returns just after its accept edge.
    task automatic issue(input logic [1:0] op, input logic [7:0] data, input bit expect_done);
        exp_t x;
        bit got;
        x.d = cur_d; x.lat = LAT; x.first = FIRST;
        x.e_n = 0; x.rn_n = 0; x.setn_n = 0;
        case (op)
            OPW: begin
                x.d = data; x.e_n = 2;
                if (expect_done) cur_d = data;
                if (RB == 1 && force_en && force_val != data) exp_err = 1'b1;
            end
            OPC: x.rn_n = 2;
            OPP: x.setn_n = 2;
            default: begin x.lat = 1; x.first = 0; end
        endcase
        x.err = exp_err;
        if (expect_done) sb.push_back(x);
        REQ_VALID = 1'b1; REQ_OP = op; REQ_DATA = data;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge CLK);
            if (REQ_READY) got = 1'b1;
        end
        chk("accept_seen", 32'(got), 32'd1);
        @(posedge CLK); #1;
        REQ_VALID = 1'b0; REQ_OP = OPN; REQ_DATA = 8'h00;
    endtask

    // Wait for every pushed expectation to be consumed, then resync after an edge.
    task automatic wait_idle();
        for (int i = 0; i < 40 && sb.size() > 0; i++) @(negedge CLK);
        chk("sb_drain", 32'(sb.size()), 32'd0);
        @(negedge CLK);
        @(posedge CLK); #1;
    endtask

    initial begin
        bit seen;
        // 1: two reset cycles, then release
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_ready", 32'(REQ_READY), 32'd0);
        chk("rst_e", 32'(E), 32'd0);
        chk("rst_rn", 32'(RN), 32'd1);
        chk("rst_setn", 32'(SETN), 32'd1);
        chk("rst_d", 32'(D), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_err", 32'(ERR), 32'd0);
        RST = 1'b0;
        @(negedge CLK);
        chk("rel_ready", 32'(REQ_READY), 32'd1);
        chk("rel_e", 32'(E), 32'd0);
        chk("rel_rn_setn", 32'({RN, SETN}), 32'd3);
        chk("rel_d", 32'(D), 32'd0);
        @(posedge CLK); #1;

        // 2: single write
        issue(OPW, 8'hA5, 1'b1);
        wait_idle();

        // 3: clear then preset, second accepted in the DONE cycle
        issue(OPC, 8'h00, 1'b1);
        issue(OPP, 8'h00, 1'b1);
        wait_idle();

        // 4: reset during the pulse of a write
        issue(OPW, 8'h3C, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge CLK);
            if (E) seen = 1'b1;
        end
        chk("abort_e_seen", 32'(seen), 32'd1);
        RST = 1'b1;
        @(negedge CLK);
        chk("abort_e_low", 32'(E), 32'd0);
        chk("abort_d_kept", 32'(D), 32'h3C);
        chk("abort_rn_setn", 32'({RN, SETN}), 32'd3);
        chk("abort_ready", 32'(REQ_READY), 32'd0);
        @(negedge CLK);
        chk("abort_d_clr", 32'(D), 32'd0);
        cur_d = 8'h00;
        RST = 1'b0;
        @(negedge CLK);
        chk("abort_ready_back", 32'(REQ_READY), 32'd1);
        repeat (4) @(negedge CLK);
        @(posedge CLK); #1;

        // 5: valid held while busy, nop chained and nop from idle
        issue(OPW, 8'h5A, 1'b1);
        issue(OPN, 8'hFF, 1'b1);
        wait_idle();
        issue(OPN, 8'h00, 1'b1);
        wait_idle();
        issue(OPP, 8'h00, 1'b1);
        wait_idle();

        // 6: readback mismatch, then a matching write (ERR sticky)
        force_en = 1'b1; force_val = 8'h0E;
        issue(OPW, 8'h0F, 1'b1);
        wait_idle();
        force_en = 1'b0;
        issue(OPW, 8'h81, 1'b1);
        wait_idle();
        chk("err_sticky", 32'(ERR), 32'(RB));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
